interp8: RTL and testbench

Linear-interpolation upsampler that takes a low-rate 8-bit sample stream and produces 8 output samples per input. The outputs step evenly from the previous input sample toward the current one. It is the reconstruction counterpart of the 8-sample averaging/decimation path: it sits after a decimated stream and restores the original rate. Both sides use valid/ready handshakes so it can be backpressured by a DAC or serializer.

---
 rtl/interp8_if.sv | 11 +
 rtl/interp8.sv | 64 ++++++
 tb/tb_interp8.sv | 127 ++++++++++++
 3 files changed

// File: rtl/interp8_if.sv
// interp8_if: valid/ready sample bus for the interp8 upsampler.
interface interp8_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] SampleIN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] SampleOUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  modport master (output SampleIN, IN_VALID, OUT_READY, input IN_READY, SampleOUT, OUT_VALID);
  modport slave  (input SampleIN, IN_VALID, OUT_READY, output IN_READY, SampleOUT, OUT_VALID);
endinterface

// File: rtl/interp8.sv
// interp8: linear-interpolation upsampler, 2**LOG2R outputs per input,
// stepping from the previous input sample toward the current one.
module interp8 #(
  parameter int WIDTH = 8,
  parameter int LOG2R = 3
) (
  input logic CLK,
  input logic RST_N,
  interp8_if.slave bus
);
  localparam logic [0:0] WAIT_IN = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d;
  logic [LOG2R-1:0] k_q, k_d;
  logic signed [WIDTH:0]       diff;
  logic signed [WIDTH+LOG2R:0] dx, kx, prod, step;
  logic last, in_xfer, out_xfer;
  assign last          = k_q == {LOG2R{1'b1}};
  assign bus.OUT_VALID = state_q == EMIT;
  assign bus.IN_READY  = (state_q == WAIT_IN) | (state_q == EMIT & last & bus.OUT_READY);
  assign in_xfer       = bus.IN_VALID & bus.IN_READY;
  assign out_xfer      = bus.OUT_VALID & bus.OUT_READY;
  // floor(K*(CUR-PREV)/R) via signed multiply and arithmetic shift; result stays within [PREV,CUR]
  assign diff          = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
  assign dx            = {{LOG2R{diff[WIDTH]}}, diff};
  assign kx            = {{(WIDTH+1){1'b0}}, k_q};
  assign prod          = dx * kx;
  assign step          = prod >>> LOG2R;
  assign bus.SampleOUT = prev_q + step[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    k_d     = k_q;
    if (state_q == WAIT_IN) begin
      if (in_xfer) begin
        cur_d   = bus.SampleIN;
        k_d     = '0;
        state_d = EMIT;
      end
    end else if (out_xfer) begin
      k_d = last ? '0 : k_q + 1'b1;
      if (last) begin
        prev_d  = cur_q;
        cur_d   = in_xfer ? bus.SampleIN : cur_q;
        state_d = in_xfer ? EMIT : WAIT_IN;
      end
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WAIT_IN;
      prev_q  <= '0;
      cur_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      k_q     <= k_d;
    end
  end
endmodule

// File: tb/tb_interp8.sv
// tb_interp8: directed vector table plus hand-written back-to-back,
// backpressure and mid-burst reset sequences for interp8.
module tb_interp8;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;
  interp8_if #(.WIDTH(8)) bus();
  interp8 #(.WIDTH(8), .LOG2R(3)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  typedef struct {
    logic [7:0]      s;
    logic [0:7][7:0] e;
  } vec_t;
  vec_t v [7];
  int errors = 0;
  int checks = 0;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic send(logic [7:0] s);
    int n = 0;
    @(negedge CLK);
    bus.IN_VALID = 1'b1;
    bus.SampleIN = s;
    #1;
    while (!bus.IN_READY && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("send_in_ready", 32'(bus.IN_READY), 1);
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
  endtask
  task automatic burst(logic [0:7][7:0] e, int id);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge CLK);
      #1;
      check($sformatf("v%0d_k%0d_valid", id, k), 32'(bus.OUT_VALID), 1);
      check($sformatf("v%0d_k%0d_sample", id, k), 32'(bus.SampleOUT), 32'(e[k]));
    end
    @(negedge CLK);
    #1;
    check($sformatf("v%0d_end_valid", id), 32'(bus.OUT_VALID), 0);
    check($sformatf("v%0d_end_in_ready", id), 32'(bus.IN_READY), 1);
  endtask
  initial begin
    int n;
    v[0].s = 8'd16;  v[0].e = {8'd0, 8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14};
    v[1].s = 8'd0;   v[1].e = {8'd16, 8'd14, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2};
    v[2].s = 8'd8;   v[2].e = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    v[3].s = 8'd0;   v[3].e = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    v[4].s = 8'd255; v[4].e = {8'd0, 8'd31, 8'd63, 8'd95, 8'd127, 8'd159, 8'd191, 8'd223};
    v[5].s = 8'd255; v[5].e = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    v[6].s = 8'd0;   v[6].e = {8'd255, 8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31};
    bus.IN_VALID = 1'b0;
    bus.SampleIN = 8'd0;
    bus.OUT_READY = 1'b1;
    #12;
    check("rst_out_valid", 32'(bus.OUT_VALID), 0);
    check("rst_in_ready", 32'(bus.IN_READY), 1);
    check("rst_sample", 32'(bus.SampleOUT), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(v[i].s);
      burst(v[i].e, i);
    end
    // back-to-back 40, 80, 120 starting from PREV=0
    @(negedge CLK);
    bus.IN_VALID = 1'b1;
    bus.SampleIN = 8'd40;
    @(negedge CLK);
    for (int c = 0; c < 24; c++) begin
      bus.IN_VALID = (c / 8) < 2;
      bus.SampleIN = 8'(40 * (c / 8 + 2));
      #1;
      check($sformatf("b2b_c%0d_valid", c), 32'(bus.OUT_VALID), 1);
      check($sformatf("b2b_c%0d_sample", c), 32'(bus.SampleOUT), 32'(40 * (c / 8) + 5 * (c % 8)));
      check($sformatf("b2b_c%0d_in_ready", c), 32'(bus.IN_READY), 32'(c % 8 == 7));
      @(negedge CLK);
    end
    bus.IN_VALID = 1'b0;
    #1;
    check("b2b_end_valid", 32'(bus.OUT_VALID), 0);
    // backpressure on a 0 -> 64 burst
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    send(8'd64);
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      bus.OUT_READY = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("bp_c%0d_valid", c), 32'(bus.OUT_VALID), 1);
      check($sformatf("bp_c%0d_sample", c), 32'(bus.SampleOUT), 32'(8 * n));
      if (bus.OUT_READY) n++;
      @(negedge CLK);
    end
    check("bp_count", 32'(n), 8);
    bus.OUT_READY = 1'b1;
    #1;
    check("bp_end_valid", 32'(bus.OUT_VALID), 0);
    // asynchronous reset at K=3 of a 64 -> 0 burst
    send(8'd0);
    #1;
    check("mid_k0", 32'(bus.SampleOUT), 64);
    repeat (3) @(negedge CLK);
    #1;
    check("mid_k3", 32'(bus.SampleOUT), 40);
    RST_N = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.OUT_VALID), 0);
    check("mid_rst_in_ready", 32'(bus.IN_READY), 1);
    check("mid_rst_sample", 32'(bus.SampleOUT), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    send(8'd32);
    burst({8'd0, 8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24, 8'd28}, 99);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
